// File: rtl/reg_file_mem_if.sv
// Bus bundle for reg_file_mem: write port, read port, clear request and status.
// The master drives requests and the slave (the memory) returns read data and status.
interface reg_file_mem_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned ADDR_W = 2
);
    logic              WE;
    logic [ADDR_W-1:0] WADDR;
    logic [WIDTH-1:0]  D;
    logic              RE;
    logic [ADDR_W-1:0] RADDR;
    logic              CLR;
    logic [WIDTH-1:0]  Q;
    logic              QV;
    logic              BUSY;

    modport master (
        output WE, WADDR, D, RE, RADDR, CLR,
        input  Q, QV, BUSY
    );

    modport slave (
        input  WE, WADDR, D, RE, RADDR, CLR,
        output Q, QV, BUSY
    );
endinterface

// File: rtl/reg_file_mem.sv
// Clocked register file: one synchronous write port, one registered read port with a valid strobe,
// write-first bypass, and a hardware sweep that clears every word once per CLR request.
module reg_file_mem #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned ADDR_W = 2
) (
    input  logic           CLK,
    input  logic           RST,
    reg_file_mem_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEARING
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              qv_q, qv_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        mem_d   = mem_q;
        q_d     = q_q;
        qv_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.WE) begin
                    mem_d[bus.WADDR] = bus.D;
                end
                if (bus.CLR) begin
                    state_d = CLEARING;
                    busy_d  = 1'b1;
                    ptr_d   = '0;
                end
            end
            CLEARING: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Reading the next-state array gives write-first and clear bypass in one place.
        if (bus.RE) begin
            q_d  = mem_d[bus.RADDR];
            qv_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.QV   = qv_q;
    assign bus.BUSY = busy_q;
endmodule
